// File: rtl/blake2_msg_framer_if.sv
`default_nettype none
// ============================================================================
//  Module   : blake2_msg_framer_if
//  Purpose  : Bundles the upstream byte stream and the downstream blake2 core
//             block interface of the message framer.
//             The master modport is the framer's view.
//             The slave modport is the environment's view.
//             BLAKE2_FRAMER_EMPTY_MSG_EN adds in_empty_i, the request for a
//             zero-length message.
//  Revision : 1.0 - initial release
// ============================================================================
interface blake2_msg_framer_if #(
    parameter int BB       = 64,
    parameter int BB_CLOG2 = $clog2(BB),
    parameter int LL_W     = 128
);
    logic                in_v_i;
    logic [7:0]          in_data_i;
    logic                in_last_i;
`ifdef BLAKE2_FRAMER_EMPTY_MSG_EN
    logic                in_empty_i;
`endif
    logic                in_ready_o;
    logic                down_ready_i;
    logic                data_v_o;
    logic [BB_CLOG2-1:0] data_idx_o;
    logic [7:0]          data_o;
    logic                block_first_o;
    logic                block_last_o;
    logic [LL_W-1:0]     ll_o;

`ifdef BLAKE2_FRAMER_EMPTY_MSG_EN
    modport master (
        input  in_v_i, in_data_i, in_last_i, in_empty_i, down_ready_i,
        output in_ready_o, data_v_o, data_idx_o, data_o,
               block_first_o, block_last_o, ll_o
    );
    modport slave (
        output in_v_i, in_data_i, in_last_i, in_empty_i, down_ready_i,
        input  in_ready_o, data_v_o, data_idx_o, data_o,
               block_first_o, block_last_o, ll_o
    );
`else
    modport master (
        input  in_v_i, in_data_i, in_last_i, down_ready_i,
        output in_ready_o, data_v_o, data_idx_o, data_o,
               block_first_o, block_last_o, ll_o
    );
    modport slave (
        output in_v_i, in_data_i, in_last_i, down_ready_i,
        input  in_ready_o, data_v_o, data_idx_o, data_o,
               block_first_o, block_last_o, ll_o
    );
`endif
endinterface
`default_nettype wire

// File: rtl/blake2_msg_framer.sv
`default_nettype none
// ============================================================================
//  Module   : blake2_msg_framer
//  Purpose  : Converts a valid/ready byte stream with a last-byte flag into
//             the blake2 core's 64-byte block interface.
//             It generates the index and the first/last block flags.
//             It zero-pads the final block and counts the message length.
//             Optional macro BLAKE2_FRAMER_EMPTY_MSG_EN enables zero-length
//             messages via in_empty_i.
//  Revision : 1.0 - initial release
// ============================================================================
module blake2_msg_framer #(
    parameter int BB       = 64,
    parameter int BB_CLOG2 = $clog2(BB),
    parameter int LL_W     = 128
) (
    input  wire logic               clk,
    input  wire logic               nreset,
    blake2_msg_framer_if.master     bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_PAD    = 2'd2
    } state_t;

    localparam logic [BB_CLOG2-1:0] c_idx_last = BB_CLOG2'(BB - 1);

    state_t              r_state;
    logic [BB_CLOG2-1:0] r_idx;
    logic                r_first;
    logic                r_last;
    logic [LL_W-1:0]     r_ll;

    logic                w_is_idle;
    logic                w_is_pad;
    logic                w_idx_end;
    logic                w_in_ready;
    logic                w_empty_req;
    logic                w_accept;
    logic                w_xfer;
    logic [BB_CLOG2-1:0] w_idx_next;

    assign w_is_idle  = (r_state == S_IDLE);
    assign w_is_pad   = (r_state == S_PAD);
    assign w_idx_end  = (r_idx == c_idx_last);
    assign w_idx_next = w_idx_end ? '0 : r_idx + 1'b1;

    // Every output is gated by nreset so the core sees all zeros during reset.
    assign w_in_ready = nreset & bus.down_ready_i & ~w_is_pad;

`ifdef BLAKE2_FRAMER_EMPTY_MSG_EN
    // An empty-message request is handshaked like a byte but carries no data.
    assign w_empty_req = w_is_idle & bus.in_v_i & bus.in_empty_i & w_in_ready;
`else
    assign w_empty_req = 1'b0;
`endif

    assign w_accept = bus.in_v_i & w_in_ready & ~w_empty_req;
    assign w_xfer   = w_accept | (nreset & bus.down_ready_i & w_is_pad);

    assign bus.in_ready_o    = w_in_ready;
    assign bus.data_v_o      = w_xfer;
    assign bus.data_idx_o    = r_idx;
    assign bus.data_o        = (nreset & ~w_is_pad) ? bus.in_data_i : 8'h00;
    assign bus.block_first_o = nreset & (w_is_idle | r_first);
    assign bus.block_last_o  = nreset & (r_last | (w_accept & bus.in_last_i) | w_is_pad);
    assign bus.ll_o          = r_ll;

    // Framing FSM: advances the index on every beat and tracks the flags and length.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_ll    <= '0;
        end else if (w_empty_req) begin
            // A whole block of padding stands in for the absent data.
            r_state <= S_PAD;
            r_idx   <= '0;
            r_first <= 1'b1;
            r_last  <= 1'b1;
            r_ll    <= '0;
        end else if (w_xfer) begin
            r_idx <= w_idx_next;
            case (r_state)
                S_IDLE, S_STREAM: begin
                    if (w_is_idle) begin
                        r_ll    <= LL_W'(1);
                        r_first <= ~w_idx_end;
                        r_state <= S_STREAM;
                    end else begin
                        r_ll <= r_ll + LL_W'(1);
                        if (w_idx_end) begin
                            r_first <= 1'b0;
                        end
                    end
                    if (bus.in_last_i) begin
                        if (w_idx_end) begin
                            // Message length is an exact multiple of the block size: no pad.
                            r_state <= S_IDLE;
                            r_first <= 1'b0;
                            r_last  <= 1'b0;
                        end else begin
                            r_state <= S_PAD;
                            r_last  <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    if (w_idx_end) begin
                        r_state <= S_IDLE;
                        r_first <= 1'b0;
                        r_last  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_blake2_msg_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_blake2_msg_framer
//  Purpose  : Directed self-checking bench for blake2_msg_framer.
//             Each beat is compared as one packed vector:
//             {data_v, idx, data, first, last, in_ready}.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_blake2_msg_framer;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    blake2_msg_framer_if #(.BB(64), .BB_CLOG2(6), .LL_W(128)) bus ();

    blake2_msg_framer #(.BB(64), .BB_CLOG2(6), .LL_W(128)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    wire [17:0] obs = {bus.data_v_o, bus.data_idx_o, bus.data_o,
                       bus.block_first_o, bus.block_last_o, bus.in_ready_o};

    logic [17:0] exp_v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        bus.down_ready_i = 1'b1;
        bus.in_v_i = 1'b1;
        bus.in_data_i = 8'hAA;
        bus.in_last_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (obs !== 18'h0 || bus.ll_o !== 128'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h ll=%0d, want 00000 ll=0", obs, bus.ll_o);
        end
        bus.in_v_i = 1'b0;
        bus.in_last_i = 1'b0;
        bus.in_data_i = 8'h00;
        tick();
        nreset = 1'b1;
        @(negedge clk);
        exp_v = {1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 1'b1};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL reset_idle: got %h want %h", obs, exp_v);
        end
        tick();
    endtask

    task automatic test_abc();
        for (int b = 0; b < 64; b++) begin
            bus.in_v_i    = (b < 3);
            bus.in_data_i = (b < 3) ? 8'(8'h61 + b) : 8'hEE;
            bus.in_last_i = (b == 2);
            @(negedge clk);
            // block_last cannot rise before the last byte is actually offered.
            exp_v = {1'b1, 6'(b), (b < 3) ? 8'(8'h61 + b) : 8'h00, 1'b1, (b >= 2), (b < 3)};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL abc_beat%0d: got %h want %h", b, obs, exp_v);
            end
            tick();
        end
        bus.in_v_i = 1'b0;
        bus.in_last_i = 1'b0;
        bus.in_data_i = 8'h00;
        @(negedge clk);
        exp_v = {1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 1'b1};
        tests++;
        if (obs !== exp_v || bus.ll_o !== 128'd3) begin
            fails++;
            $display("FAIL abc_done: got %h ll=%0d, want %h ll=3", obs, bus.ll_o, exp_v);
        end
        tick();
    endtask

    task automatic test_full64();
        for (int b = 0; b < 64; b++) begin
            bus.in_v_i    = 1'b1;
            bus.in_data_i = 8'(b);
            bus.in_last_i = (b == 63);
            @(negedge clk);
            exp_v = {1'b1, 6'(b), 8'(b), 1'b1, (b == 63), 1'b1};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL full64_beat%0d: got %h want %h", b, obs, exp_v);
            end
            tick();
        end
        bus.in_v_i = 1'b0;
        bus.in_last_i = 1'b0;
        bus.in_data_i = 8'h00;
        @(negedge clk);
        exp_v = {1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 1'b1};
        tests++;
        if (obs !== exp_v || bus.ll_o !== 128'd64) begin
            fails++;
            $display("FAIL full64_done: got %h ll=%0d, want %h ll=64", obs, bus.ll_o, exp_v);
        end
        tick();
    endtask

    task automatic test_65_with_gap();
        for (int b = 0; b < 64; b++) begin
            bus.in_v_i    = 1'b1;
            bus.in_data_i = 8'(b) ^ 8'h5A;
            bus.in_last_i = 1'b0;
            @(negedge clk);
            exp_v = {1'b1, 6'(b), 8'(b) ^ 8'h5A, 1'b1, 1'b0, 1'b1};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL b65_blk0_beat%0d: got %h want %h", b, obs, exp_v);
            end
            tick();
        end
        // The core drops ready while it compresses block 0.
        bus.down_ready_i = 1'b0;
        bus.in_v_i = 1'b1;
        bus.in_data_i = 8'h77;
        bus.in_last_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exp_v = {1'b0, 6'd0, 8'h77, 1'b0, 1'b0, 1'b0};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL b65_gap%0d: got %h want %h", c, obs, exp_v);
            end
            tick();
        end
        bus.down_ready_i = 1'b1;
        @(negedge clk);
        exp_v = {1'b1, 6'd0, 8'h77, 1'b0, 1'b1, 1'b1};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL b65_blk1_byte0: got %h want %h", obs, exp_v);
        end
        tick();
        bus.in_v_i = 1'b0;
        bus.in_last_i = 1'b0;
        bus.in_data_i = 8'h00;
        for (int b = 1; b < 64; b++) begin
            @(negedge clk);
            exp_v = {1'b1, 6'(b), 8'h00, 1'b0, 1'b1, 1'b0};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL b65_pad%0d: got %h want %h", b, obs, exp_v);
            end
            tick();
        end
        @(negedge clk);
        tests++;
        if (bus.ll_o !== 128'd65) begin
            fails++;
            $display("FAIL b65_ll: got %0d want 65", bus.ll_o);
        end
        tick();
    endtask

    task automatic test_stall();
        for (int b = 0; b < 64; b++) begin
            if (b == 20) begin
                bus.down_ready_i = 1'b0;
                bus.in_v_i = 1'b1;
                bus.in_data_i = 8'h24;
                bus.in_last_i = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    exp_v = {1'b0, 6'd20, 8'h24, 1'b1, 1'b0, 1'b0};
                    tests++;
                    if (obs !== exp_v) begin
                        fails++;
                        $display("FAIL stall%0d: got %h want %h", c, obs, exp_v);
                    end
                    tick();
                end
                bus.down_ready_i = 1'b1;
            end
            bus.in_v_i    = (b < 30);
            bus.in_data_i = (b < 30) ? 8'(b + 8'h10) : 8'h00;
            bus.in_last_i = (b == 29);
            @(negedge clk);
            exp_v = {1'b1, 6'(b), (b < 30) ? 8'(b + 8'h10) : 8'h00, 1'b1, (b >= 29), (b < 30)};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL stall_beat%0d: got %h want %h", b, obs, exp_v);
            end
            tick();
        end
        bus.in_v_i = 1'b0;
        bus.in_last_i = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.ll_o !== 128'd30) begin
            fails++;
            $display("FAIL stall_ll: got %0d want 30", bus.ll_o);
        end
        tick();
    endtask

    task automatic test_reset_in_pad();
        for (int b = 0; b < 40; b++) begin
            bus.in_v_i    = (b < 5);
            bus.in_data_i = (b < 5) ? 8'(b + 1) : 8'h00;
            bus.in_last_i = (b == 4);
            tick();
        end
        bus.in_v_i = 1'b0;
        bus.in_last_i = 1'b0;
        #1;
        exp_v = {1'b1, 6'd40, 8'h00, 1'b1, 1'b1, 1'b0};
        tests++;
        if (obs !== exp_v || bus.ll_o !== 128'd5) begin
            fails++;
            $display("FAIL rstpad_pre: got %h ll=%0d, want %h ll=5", obs, bus.ll_o, exp_v);
        end
        nreset = 1'b0;
        #1;
        tests++;
        if (obs !== 18'h0 || bus.ll_o !== 128'd0) begin
            fails++;
            $display("FAIL rstpad_async: got %h ll=%0d, want 00000 ll=0", obs, bus.ll_o);
        end
        tick();
        nreset = 1'b1;
        bus.in_v_i = 1'b1;
        bus.in_data_i = 8'hC3;
        bus.in_last_i = 1'b1;
        @(negedge clk);
        exp_v = {1'b1, 6'd0, 8'hC3, 1'b1, 1'b1, 1'b1};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL rstpad_1byte: got %h want %h", obs, exp_v);
        end
        tick();
        bus.in_v_i = 1'b0;
        bus.in_last_i = 1'b0;
        bus.in_data_i = 8'h00;
        for (int b = 1; b < 64; b++) begin
            @(negedge clk);
            exp_v = {1'b1, 6'(b), 8'h00, 1'b1, 1'b1, 1'b0};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL rstpad_pad%0d: got %h want %h", b, obs, exp_v);
            end
            tick();
        end
        @(negedge clk);
        exp_v = {1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 1'b1};
        tests++;
        if (obs !== exp_v || bus.ll_o !== 128'd1) begin
            fails++;
            $display("FAIL rstpad_done: got %h ll=%0d, want %h ll=1", obs, bus.ll_o, exp_v);
        end
        tick();
    endtask

`ifdef BLAKE2_FRAMER_EMPTY_MSG_EN
    task automatic test_empty();
        bus.in_v_i = 1'b1;
        bus.in_empty_i = 1'b1;
        bus.in_data_i = 8'h99;
        @(negedge clk);
        exp_v = {1'b0, 6'd0, 8'h99, 1'b1, 1'b0, 1'b1};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL empty_req: got %h want %h", obs, exp_v);
        end
        tick();
        bus.in_v_i = 1'b0;
        bus.in_empty_i = 1'b0;
        bus.in_data_i = 8'h00;
        for (int b = 0; b < 64; b++) begin
            @(negedge clk);
            exp_v = {1'b1, 6'(b), 8'h00, 1'b1, 1'b1, 1'b0};
            tests++;
            if (obs !== exp_v || bus.ll_o !== 128'd0) begin
                fails++;
                $display("FAIL empty_beat%0d: got %h ll=%0d, want %h ll=0", b, obs, bus.ll_o, exp_v);
            end
            tick();
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_v_i = 1'b0;
        bus.in_data_i = 8'h00;
        bus.in_last_i = 1'b0;
        bus.down_ready_i = 1'b0;
`ifdef BLAKE2_FRAMER_EMPTY_MSG_EN
        bus.in_empty_i = 1'b0;
`endif
        test_reset();
        test_abc();
        test_full64();
        test_65_with_gap();
        test_stall();
        test_reset_in_pad();
`ifdef BLAKE2_FRAMER_EMPTY_MSG_EN
        test_empty();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
